// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART (programmable UART).
// Contents: bus/divisor widths, oversample constants, I/O address map,
// and the transmit/receive state encodings.
package spart_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned DB_W       = 16;
  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned OS_W       = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W      = $clog2(DATA_W);

  // Divisor for 9600 baud at 50 MHz with 16x oversampling.
  localparam logic [DB_W-1:0] DEFAULT_DB = 16'd325;

  // Last enable of a full bit time, and the enable that lands mid start bit.
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ADDR_BUF    = 2'b00,
    ADDR_STATUS = 2'b01,
    ADDR_DB_LO  = 2'b10,
    ADDR_DB_HI  = 2'b11
  } ioaddr_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud-rate enable generator: 16-bit down-counter that pulses and reloads
// from the divisor when it reaches zero, giving one enable every db+1 cycles.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   db            divisor value
//   reload        force an immediate reload from db (after a divisor write)
//   baud_en_c     one-cycle enable, combinational from the counter state
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter logic [DB_W-1:0] RST_DB = DEFAULT_DB
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DB_W-1:0] db,
  input  logic            reload,
  output logic            baud_en_c
);

  logic [DB_W-1:0] cnt;

  assign baud_en_c = (cnt == '0);

  // Down-counter with reload on zero or on divisor update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RST_DB;
    end else if (reload || (cnt == '0)) begin
      cnt <= db;
    end else begin
      cnt <= cnt - DB_W'(1);
    end
  end

endmodule

// File: rtl/spart.sv
// SPART: programmable 8N1 UART with a small processor bus interface.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   iocs, iorw    chip select and read(1)/write(0) strobe
//   ioaddr        00 tx/rx buffer, 01 status, 10 divisor low, 11 divisor high
//   databus       bidirectional data, driven only during selected reads
//   rda, tbr      receive data available, transmit buffer ready
//   txd, rxd      serial out (idle high), serial in (asynchronous)
module spart
  import spart_pkg::*;
#(
  parameter logic [DB_W-1:0] RST_DB = DEFAULT_DB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iocs,
  input  logic              iorw,
  input  logic [1:0]        ioaddr,
  inout  wire  [DATA_W-1:0] databus,
  output logic              rda,
  output logic              tbr,
  output logic              txd,
  input  logic              rxd
);

  ioaddr_e            addr_c;
  logic               wr_c, rd_c, tx_wr_c, rx_rd_c, db_wr_c;
  logic [DATA_W-1:0]  rd_data_c;
  logic [DB_W-1:0]    db_q;
  logic               db_reload_q;
  logic               baud_en_c;

  // Transmit state
  tx_state_e          tx_state, tx_state_n;
  logic [DATA_W-1:0]  tx_shift, tx_shift_n;
  logic [BIT_W-1:0]   tx_bit, tx_bit_n;
  logic [OS_W-1:0]    tx_os, tx_os_n;
  logic               tx_pend, tx_pend_n;
  logic               txd_n, tbr_n;

  // Receive state
  rx_state_e          rx_state, rx_state_n;
  logic [DATA_W-1:0]  rx_shift, rx_shift_n;
  logic [DATA_W-1:0]  rx_buf, rx_buf_n;
  logic [BIT_W-1:0]   rx_bit, rx_bit_n;
  logic [OS_W-1:0]    rx_os, rx_os_n;
  logic [1:0]         rx_sync;
  logic               rx_s;
  logic               rda_n;

  assign addr_c  = ioaddr_e'(ioaddr);
  assign wr_c    = iocs && !iorw;
  assign rd_c    = iocs && iorw;
  assign db_wr_c = wr_c && ((addr_c == ADDR_DB_LO) || (addr_c == ADDR_DB_HI));
  // A tx write is only accepted while the transmitter is fully idle.
  assign tx_wr_c = wr_c && (addr_c == ADDR_BUF) && (tx_state == TX_IDLE) && tbr;
  assign rx_rd_c = rd_c && (addr_c == ADDR_BUF);
  assign rx_s    = rx_sync[1];

  // Read-data mux.
  always_comb begin
    rd_data_c = '0;
    case (addr_c)
      ADDR_BUF:    rd_data_c = rx_buf;
      ADDR_STATUS: rd_data_c = {6'b0, tbr, rda};
      ADDR_DB_LO:  rd_data_c = db_q[7:0];
      ADDR_DB_HI:  rd_data_c = db_q[15:8];
      default:     rd_data_c = '0;
    endcase
  end

  assign databus = rd_c ? rd_data_c : {DATA_W{1'bz}};

  // Divisor register; the strobe makes the counter pick up the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q        <= RST_DB;
      db_reload_q <= 1'b0;
    end else begin
      db_reload_q <= db_wr_c;
      if (wr_c && (addr_c == ADDR_DB_LO)) db_q[7:0]  <= databus;
      if (wr_c && (addr_c == ADDR_DB_HI)) db_q[15:8] <= databus;
    end
  end

  spart_baud_gen #(
    .RST_DB (RST_DB)
  ) u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .db        (db_q),
    .reload    (db_reload_q),
    .baud_en_c (baud_en_c)
  );

  // Transmit next-state; a write only arms tx_pend, the frame starts on the next enable.
  always_comb begin
    tx_state_n = tx_state;
    tx_shift_n = tx_shift;
    tx_bit_n   = tx_bit;
    tx_os_n    = tx_os;
    tx_pend_n  = tx_pend;
    txd_n      = txd;
    tbr_n      = tbr;
    case (tx_state)
      TX_IDLE: begin
        if (tx_wr_c) begin
          tx_shift_n = databus;
          tx_pend_n  = 1'b1;
          tbr_n      = 1'b0;
        end
        if (tx_pend && baud_en_c) begin
          tx_state_n = TX_START;
          tx_pend_n  = 1'b0;
          txd_n      = 1'b0;
          tx_os_n    = '0;
        end
      end
      TX_START: begin
        if (baud_en_c) begin
          tx_os_n = tx_os + OS_W'(1);
          if (tx_os == OS_LAST) begin
            tx_state_n = TX_DATA;
            tx_bit_n   = '0;
            txd_n      = tx_shift[0];
          end
        end
      end
      TX_DATA: begin
        if (baud_en_c) begin
          tx_os_n = tx_os + OS_W'(1);
          if (tx_os == OS_LAST) begin
            if (tx_bit == BIT_LAST) begin
              tx_state_n = TX_STOP;
              txd_n      = 1'b1;
            end else begin
              tx_bit_n   = tx_bit + BIT_W'(1);
              tx_shift_n = {1'b0, tx_shift[DATA_W-1:1]};
              txd_n      = tx_shift[1];
            end
          end
        end
      end
      TX_STOP: begin
        if (baud_en_c) begin
          tx_os_n = tx_os + OS_W'(1);
          if (tx_os == OS_LAST) begin
            tx_state_n = TX_IDLE;
            tbr_n      = 1'b1;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_bit   <= '0;
      tx_os    <= '0;
      tx_pend  <= 1'b0;
      txd      <= 1'b1;
      tbr      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_shift <= tx_shift_n;
      tx_bit   <= tx_bit_n;
      tx_os    <= tx_os_n;
      tx_pend  <= tx_pend_n;
      txd      <= txd_n;
      tbr      <= tbr_n;
    end
  end

  // Receive next-state; a load in the same cycle as a buffer read keeps rda set.
  always_comb begin
    rx_state_n = rx_state;
    rx_shift_n = rx_shift;
    rx_buf_n   = rx_buf;
    rx_bit_n   = rx_bit;
    rx_os_n    = rx_os;
    rda_n      = rda;
    if (rx_rd_c) rda_n = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_n = RX_START;
          rx_os_n    = '0;
        end
      end
      RX_START: begin
        if (baud_en_c) begin
          rx_os_n = rx_os + OS_W'(1);
          // Mid start bit: a high line here was a glitch.
          if (rx_os == OS_MID) begin
            if (rx_s) begin
              rx_state_n = RX_IDLE;
            end else begin
              rx_state_n = RX_DATA;
              rx_os_n    = '0;
              rx_bit_n   = '0;
            end
          end
        end
      end
      RX_DATA: begin
        if (baud_en_c) begin
          rx_os_n = rx_os + OS_W'(1);
          if (rx_os == OS_LAST) begin
            rx_shift_n = {rx_s, rx_shift[DATA_W-1:1]};
            rx_bit_n   = rx_bit + BIT_W'(1);
            if (rx_bit == BIT_LAST) rx_state_n = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (baud_en_c) begin
          rx_os_n = rx_os + OS_W'(1);
          if (rx_os == OS_LAST) begin
            rx_state_n = RX_IDLE;
            // Framing error drops the byte silently.
            if (rx_s) begin
              rx_buf_n = rx_shift;
              rda_n    = 1'b1;
            end
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync  <= 2'b11;
      rx_state <= RX_IDLE;
      rx_shift <= '0;
      rx_buf   <= '0;
      rx_bit   <= '0;
      rx_os    <= '0;
      rda      <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], rxd};
      rx_state <= rx_state_n;
      rx_shift <= rx_shift_n;
      rx_buf   <= rx_buf_n;
      rx_bit   <= rx_bit_n;
      rx_os    <= rx_os_n;
      rda      <= rda_n;
    end
  end

endmodule

// File: tb/tb_spart.sv
// Directed self-checking bench for spart: register access, tx framing,
// loopback receive, glitch and framing-error rejection, overrun, reset abort.
module tb_spart;

  logic       clk = 1'b0;
  logic       rst;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda, tbr, txd;
  wire        rxd;

  logic       tb_drv;
  logic [7:0] tb_data;
  logic       loop_en;
  logic       rxd_drv;

  int n_tests = 0;
  int n_fail  = 0;

  assign databus = tb_drv ? tb_data : 8'hzz;
  assign rxd     = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  spart dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .databus (databus),
    .rda     (rda),
    .tbr     (tbr),
    .txd     (txd),
    .rxd     (rxd)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_data = d; tb_drv = 1'b1;
    tick(1);
    iocs = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    tick(1);
    iocs = 1'b0; iorw = 1'b0;
  endtask

  task automatic set_db4();
    bus_write(2'b10, 8'h04);
    bus_write(2'b11, 8'h00);
  endtask

  // Divisor 4 -> 80 clocks per bit. Checks each bit at its midpoint and tbr timing.
  task automatic expect_tx(input logic [7:0] b);
    bit seen = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (txd == 1'b0) begin
        seen = 1'b1;
        break;
      end
      tick(1);
    end
    if (!seen) begin
      check("tx_start_seen", 16'd0, 16'd1);
      return;
    end
    tick(40);
    check("tx_start_bit", 16'(txd), 16'd0);
    for (int k = 0; k < 8; k++) begin
      tick(80);
      check($sformatf("tx_data_bit%0d", k), 16'(txd), 16'(b[k]));
    end
    tick(80);
    check("tx_stop_bit", 16'(txd), 16'd1);
    tick(39);
    check("tbr_before_end", 16'(tbr), 16'd0);
    tick(1);
    check("tbr_at_end", 16'(tbr), 16'd1);
  endtask

  // Bit-banged 8N1 frame into rxd at 80 clocks per bit.
  task automatic send_serial(input logic [7:0] b, input logic stop, input int stop_len);
    rxd_drv = 1'b0;
    tick(80);
    for (int k = 0; k < 8; k++) begin
      rxd_drv = b[k];
      tick(80);
    end
    rxd_drv = stop;
    tick(stop_len);
    rxd_drv = 1'b1;
    tick(120);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    rst = 1'b1; iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b00;
    tb_drv = 1'b0; tb_data = 8'h00; loop_en = 1'b0; rxd_drv = 1'b1;
    tick(3);
    rst = 1'b0;

    // Reset state
    check("rst_txd", 16'(txd), 16'd1);
    check("rst_tbr", 16'(tbr), 16'd1);
    check("rst_rda", 16'(rda), 16'd0);
    bus_read(2'b01, rd); check("rst_status", 16'(rd), 16'h02);
    bus_read(2'b10, rd); check("rst_db_lo", 16'(rd), 16'h45);
    bus_read(2'b11, rd); check("rst_db_hi", 16'(rd), 16'h01);
    bus_read(2'b00, rd); check("rst_rxbuf", 16'(rd), 16'h00);

    // Transmit 0xA5 at divisor 4
    set_db4();
    bus_read(2'b10, rd); check("db_lo_wr", 16'(rd), 16'h04);
    bus_write(2'b00, 8'hA5);
    check("tbr_drop", 16'(tbr), 16'd0);
    bus_write(2'b00, 8'h00);   // ignored while busy
    expect_tx(8'hA5);

    // Loopback receive 0x3C
    loop_en = 1'b1;
    bus_write(2'b00, 8'h3C);
    expect_tx(8'h3C);
    check("loop_rda", 16'(rda), 16'd1);
    bus_read(2'b01, rd); check("loop_status", 16'(rd), 16'h03);
    bus_read(2'b00, rd); check("loop_data", 16'(rd), 16'h3C);
    check("loop_rda_clr", 16'(rda), 16'd0);
    loop_en = 1'b0;

    // Short low pulse is rejected, then a clean frame still receives
    rxd_drv = 1'b0;
    tick(20);
    rxd_drv = 1'b1;
    tick(100);
    check("glitch_rda", 16'(rda), 16'd0);
    send_serial(8'h5A, 1'b1, 80);
    check("post_glitch_rda", 16'(rda), 16'd1);
    bus_read(2'b00, rd); check("post_glitch_data", 16'(rd), 16'h5A);
    check("post_glitch_rda_clr", 16'(rda), 16'd0);

    // Framing error: byte discarded, buffer keeps previous value
    send_serial(8'hC3, 1'b0, 60);
    check("frame_err_rda", 16'(rda), 16'd0);
    bus_read(2'b00, rd); check("frame_err_buf", 16'(rd), 16'h5A);

    // Overrun: second byte overwrites, rda stays set
    send_serial(8'h11, 1'b1, 80);
    send_serial(8'h22, 1'b1, 80);
    check("overrun_rda", 16'(rda), 16'd1);
    bus_read(2'b00, rd); check("overrun_data", 16'(rd), 16'h22);

    // Reset during the start bit of 0xFF aborts the frame
    bus_write(2'b00, 8'hFF);
    tick(30);
    check("abort_txd_before", 16'(txd), 16'd0);
    check("abort_tbr_before", 16'(tbr), 16'd0);
    rst = 1'b1;
    tick(1);
    check("abort_txd", 16'(txd), 16'd1);
    check("abort_tbr", 16'(tbr), 16'd1);
    rst = 1'b0;
    bus_read(2'b10, rd); check("abort_db_lo", 16'(rd), 16'h45);
    set_db4();
    bus_write(2'b00, 8'h81);
    check("after_rst_tbr_drop", 16'(tbr), 16'd0);
    expect_tx(8'h81);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
